sseg_capture: RTL and testbench
===============================

SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples required before a digit is captured.
REQ-002 The module SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The module SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The module SHALL have port an, input, 4, active-high one-hot digit enable of the observed display (bit i selects digit i).
REQ-005 The module SHALL have port sseg, input, 8, active-high segments: bit7 = dp, bit6..0 = a,b,c,d,e,f,g.
REQ-006 The module SHALL have port hex, output, 16, decoded frame with digit i in bits 4i+3..4i.
REQ-007 The module SHALL have port dp, output, 4, decimal-point bit per digit.
REQ-008 The module SHALL have port err, output, 4, per-digit flag for an illegal segment pattern.
REQ-009 The module SHALL have port valid, output, 1, one-cycle strobe marking a newly published frame.

Function
REQ-010 The module SHALL register {an, sseg} once per clock, and all decisions SHALL use this registered sample.
REQ-011 The module SHALL implement FSM states IDLE, WAIT, HELD; IDLE moves to WAIT unconditionally with count = 1.
REQ-012 In WAIT, a sample change SHALL reload count = 1; an unchanged sample SHALL increment count (8-bit).
REQ-013 When count equals STABLE_CYCLES in WAIT, the FSM SHALL capture the digit and enter HELD; STABLE_CYCLES = 1 captures on the first registered cycle.
REQ-014 In HELD, no further capture SHALL occur, and a sample change SHALL enter WAIT with count = 1.
REQ-015 A capture whose an is not one-hot (0000 or more than one bit set) SHALL be discarded without affecting any state.
REQ-016 Decode SHALL map segments 6..0 to a nibble: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F.
REQ-017 Any other segment pattern SHALL decode as nibble 0 with the shadow err bit set; a legal pattern SHALL clear that digit's shadow err bit.
REQ-018 A capture SHALL write the nibble, dp and err into the shadow slot for that digit and set seen[i]; recapturing the same digit before publish overwrites the slot (latest wins).
REQ-019 On the clock after seen becomes 1111, the module SHALL copy shadow to hex/dp/err, pulse valid high for exactly one cycle, and clear seen.
REQ-020 A capture in the publish cycle SHALL go into the shadow slot and set its bit in the cleared seen, so it counts toward the next frame; it SHALL NOT alter the frame being published.
REQ-021 hex, dp and err SHALL hold their values between publishes.
REQ-022 Latency: a frame's last digit becomes stable at the input on cycle t; valid SHALL assert at cycle t + STABLE_CYCLES + 1.

Reset
REQ-023 Asserting reset_n low SHALL asynchronously set FSM = IDLE, count = 0, seen = 0000, shadow = 0, sample register = 0, hex = 0000h, dp = 0000, err = 0000, valid = 0.
REQ-024 A reset mid-frame SHALL discard partially captured digits, and no valid SHALL follow until four fresh captures occur after release.
REQ-025 Reset release SHALL be synchronous to clk.

Configuration
REQ-026 Macro SSEG_CAPTURE_BLANK_EN SHALL control blank handling: when defined, pattern 0000000 decodes as nibble 0 with err = 0; when undefined, 0000000 is illegal under REQ-017.

Verification
REQ-027 Scan digits 0..3 with patterns 1, 2, 3, 4, each held 6 cycles, STABLE_CYCLES = 4 -> one valid pulse, hex = 4321h, err = 0000, dp = 0000.
REQ-028 Hold digit 2 for 3 cycles, then for 4 cycles with a 1-cycle sseg glitch between -> exactly one capture, and it uses the post-glitch value.
REQ-029 Drive an = 0011 or 0000 with a legal pattern for 10 cycles -> no seen bit set and no valid.
REQ-030 Drive digit 1 with 1010101 and dp = 1 -> err = 0010, hex[7:4] = 0, dp = 0010 at publish; with SSEG_CAPTURE_BLANK_EN, digit 1 = 0000000 gives err = 0000.
REQ-031 Assert reset_n after three digits are captured, then release and scan four digits -> outputs zero until a single valid carrying only the post-reset values.
REQ-032 Capture digit 0 in the same cycle valid pulses -> the published frame is unchanged and seen = 0001 afterwards.

Source files
------------

// File: rtl/sseg_capture.sv
// sseg_capture -- recovers the hex frame shown on a multiplexed 4-digit
// seven-segment display by watching its digit enables and segment lines.
//
// A digit is captured once {an, sseg} has stayed unchanged for STABLE_CYCLES
// registered samples. Captures land in a per-digit shadow slot. When all four
// slots have been filled, the shadow is published to hex/dp/err and valid
// strobes for one cycle.
//
// Ports
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   an      : [3:0] one-hot digit enable, bit i selects digit i
//   sseg    : [7:0] segments, bit7 = dp, bits 6..0 = a..g (active high)
//   hex     : [15:0] published frame, digit i in bits 4i+3..4i
//   dp      : [3:0] published decimal points
//   err     : [3:0] published illegal-pattern flags
//   valid   : one-cycle strobe per newly published frame
//
// Build option
//   SSEG_CAPTURE_BLANK_EN : when defined, an all-off digit (0000000) decodes
//                           to nibble 0 with no error flag.

// Segment pattern -> nibble. Unknown patterns give nibble 0 and bad = 1.
module sseg_capture_dec (
  input  logic [6:0] seg,
  output logic [3:0] nib,
  output logic       bad
);
  always_comb begin
    nib = 4'h0;
    bad = 1'b0;
    case (seg)
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b1110111: nib = 4'hA;
      7'b0011111: nib = 4'hB;
      7'b1001110: nib = 4'hC;
      7'b0111101: nib = 4'hD;
      7'b1001111: nib = 4'hE;
      7'b1000111: nib = 4'hF;
`ifdef SSEG_CAPTURE_BLANK_EN
      7'b0000000: nib = 4'h0;
`endif
      default:    bad = 1'b1;
    endcase
  end
endmodule

// One shadow slot: {err, dp, nibble}, rewritten on every capture of its digit.
module sseg_capture_slot (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       we,
  input  logic [3:0] nib,
  input  logic       dp_in,
  input  logic       bad,
  output logic [5:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= 6'd0;
    else if (we)   q <= {bad, dp_in, nib};
  end
endmodule

module sseg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] hex,
  output logic [3:0]  dp,
  output logic [3:0]  err,
  output logic        valid
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HELD = 2'd2;
  localparam logic [7:0] STB  = STABLE_CYCLES[7:0];

  logic [11:0]     samp, prev;
  logic [1:0]      state, state_d;
  logic [7:0]      count, count_d, cnt_inc;
  logic            change, fire, onehot;
  logic [3:0]      cap_sel, seen;
  logic [3:0]      nib;
  logic            bad;
  logic [3:0][5:0] shadow;

  wire [3:0] samp_an = samp[11:8];

  // prev lags samp by one cycle so a change is seen on the registered stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp <= 12'd0;
      prev <= 12'd0;
    end else begin
      samp <= {an, sseg};
      prev <= samp;
    end
  end

  assign change  = (samp != prev);
  assign cnt_inc = change ? 8'd1 : count + 8'd1;
  assign onehot  = (samp_an != 4'd0) && ((samp_an & (samp_an - 4'd1)) == 4'd0);

  // fire marks a stable digit. A change seen in HELD restarts the count at 1,
  // which already meets the threshold when STABLE_CYCLES is 1, so that case
  // captures straight away rather than bouncing through WAIT. The >= in WAIT
  // covers the single sample left over from IDLE when STABLE_CYCLES is 1.
  always_comb begin
    state_d = state;
    count_d = count;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        state_d = WAIT;
        count_d = 8'd1;
      end
      WAIT: begin
        count_d = cnt_inc;
        if (cnt_inc >= STB) begin
          fire    = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (change) begin
          count_d = 8'd1;
          if (STB == 8'd1) fire    = 1'b1;
          else             state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= 8'd0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  // A stable sample whose enable is not one-hot writes nothing.
  assign cap_sel = (fire && onehot) ? samp_an : 4'd0;

  sseg_capture_dec u_dec (
    .seg (samp[6:0]),
    .nib (nib),
    .bad (bad)
  );

  for (genvar i = 0; i < 4; i++) begin : g_slot
    sseg_capture_slot u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (cap_sel[i]),
      .nib     (nib),
      .dp_in   (samp[7]),
      .bad     (bad),
      .q       (shadow[i])
    );
  end

  // Publish copies the shadow as it stood before this edge, so a capture in
  // the publish cycle only lands in the shadow and in the freshly cleared seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen  <= 4'd0;
      hex   <= 16'd0;
      dp    <= 4'd0;
      err   <= 4'd0;
      valid <= 1'b0;
    end else begin
      valid <= (seen == 4'hF);
      seen  <= ((seen == 4'hF) ? 4'd0 : seen) | cap_sel;
      if (seen == 4'hF) begin
        for (int i = 0; i < 4; i++) begin
          hex[4*i +: 4] <= shadow[i][3:0];
          dp[i]         <= shadow[i][4];
          err[i]        <= shadow[i][5];
        end
      end
    end
  end
endmodule

// File: tb/tb_sseg_capture.sv
module tb_sseg_capture;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  an, an1;
  logic [7:0]  sseg, sseg1;
  logic [15:0] hex, hex1;
  logic [3:0]  dp, dp1, err, err1;
  logic        valid, valid1;

  int total = 0;
  int bad = 0;
  int vcnt = 0;
  int v0;

  always #5 clk = ~clk;

  sseg_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .sseg(sseg),
    .hex(hex), .dp(dp), .err(err), .valid(valid)
  );

  sseg_capture #(.STABLE_CYCLES(1)) u1 (
    .clk(clk), .reset_n(reset_n), .an(an1), .sseg(sseg1),
    .hex(hex1), .dp(dp1), .err(err1), .valid(valid1)
  );

  // counts valid-high cycles of the main instance
  always @(posedge clk) if (valid) vcnt <= vcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a; sseg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic [3:0] a, input logic [7:0] s, input int n);
    an1 = a; sseg1 = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    an = 4'd0; sseg = 8'd0; an1 = 4'd0; sseg1 = 8'd0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hex", hex, 16'h0000);
    chk("rst_dp", dp, 4'h0);
    chk("rst_err", err, 4'h0);
    chk("rst_valid", valid, 1'b0);
    reset_n = 1'b1;

    // illegal pattern on digit 1 with its dp lit: 0,err,9,F
    v0 = vcnt;
    drv(4'b0001, 8'h7E, 6);
    drv(4'b0010, 8'hD5, 6);
    drv(4'b0100, 8'h7B, 6);
    drv(4'b1000, 8'h47, 6);
    drv(4'b0000, 8'h00, 6);
    chk("err_vcnt", vcnt - v0, 1);
    chk("err_hex", hex, 16'hF900);
    chk("err_err", err, 4'b0010);
    chk("err_dp", dp, 4'b0010);

    // blank digit 1
    v0 = vcnt;
    drv(4'b0001, 8'h7E, 6);
    drv(4'b0010, 8'h00, 6);
    drv(4'b0100, 8'h7B, 6);
    drv(4'b1000, 8'h47, 6);
    drv(4'b0000, 8'h00, 6);
    chk("blank_vcnt", vcnt - v0, 1);
    chk("blank_hex", hex, 16'hF900);
    chk("blank_dp", dp, 4'b0000);
`ifdef SSEG_CAPTURE_BLANK_EN
    chk("blank_err", err, 4'b0000);
`else
    chk("blank_err", err, 4'b0010);
`endif

    // plain scan 1,2,3,4 with exact latency on the last digit
    v0 = vcnt;
    drv(4'b0001, 8'h30, 6);
    drv(4'b0010, 8'h6D, 6);
    drv(4'b0100, 8'h79, 6);
    an = 4'b1000; sseg = 8'h33;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("lat_early", valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_hit", valid, 1'b1);
    chk("scan_hex", hex, 16'h4321);
    chk("scan_err", err, 4'b0000);
    chk("scan_dp", dp, 4'b0000);
    drv(4'b0000, 8'h00, 6);
    chk("scan_vcnt", vcnt - v0, 1);
    chk("scan_hold", hex, 16'h4321);

    // digit 2: 3 cycles of '7', one-cycle glitch, then '5'
    v0 = vcnt;
    drv(4'b0001, 8'h30, 6);
    drv(4'b0010, 8'h6D, 6);
    drv(4'b0100, 8'h70, 3);
    drv(4'b0100, 8'h7F, 1);
    chk("glitch_seen_pre", dut.seen, 4'b0011);
    drv(4'b0100, 8'h5B, 5);
    chk("glitch_seen_post", dut.seen, 4'b0111);
    drv(4'b1000, 8'h33, 6);
    drv(4'b0000, 8'h00, 6);
    chk("glitch_vcnt", vcnt - v0, 1);
    chk("glitch_hex", hex, 16'h4521);

    // non-one-hot enables never capture
    v0 = vcnt;
    drv(4'b0011, 8'h30, 10);
    chk("multi_seen", dut.seen, 4'b0000);
    drv(4'b0000, 8'h30, 10);
    chk("none_seen", dut.seen, 4'b0000);
    chk("bad_an_vcnt", vcnt - v0, 0);

    // reset after three captured digits
    drv(4'b0001, 8'h77, 6);
    drv(4'b0010, 8'h1F, 6);
    drv(4'b0100, 8'h4E, 6);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_hex", hex, 16'h0000);
    chk("mid_rst_seen", dut.seen, 4'b0000);
    chk("mid_rst_valid", valid, 1'b0);
    drv(4'b0000, 8'h00, 2);
    reset_n = 1'b1;
    v0 = vcnt;
    drv(4'b0001, 8'h3D, 6);
    drv(4'b0010, 8'h4F, 6);
    drv(4'b0100, 8'h5F, 6);
    chk("post_rst_partial_hex", hex, 16'h0000);
    chk("post_rst_partial_vcnt", vcnt - v0, 0);
    drv(4'b1000, 8'h79, 6);
    drv(4'b0000, 8'h00, 6);
    chk("post_rst_vcnt", vcnt - v0, 1);
    chk("post_rst_hex", hex, 16'h36ED);
    chk("post_rst_err", err, 4'b0000);

    // STABLE_CYCLES=1: digit 0 captured in the publish cycle
    drv1(4'b0001, 8'h30, 1);
    drv1(4'b0010, 8'h6D, 1);
    drv1(4'b0100, 8'h79, 1);
    drv1(4'b1000, 8'h33, 1);
    drv1(4'b0001, 8'h7B, 1);
    an1 = 4'b0000; sseg1 = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("pub_valid", valid1, 1'b1);
    chk("pub_hex", hex1, 16'h4321);
    chk("pub_seen", u1.seen, 4'b0001);
    repeat (3) @(posedge clk);
    #1;
    chk("pub_valid_after", valid1, 1'b0);
    chk("pub_seen_after", u1.seen, 4'b0001);
    chk("pub_hex_hold", hex1, 16'h4321);
    chk("pub_err", err1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
